// File: rtl/operand_bank_pkg.sv
// Shared definitions for the operand counter bank: channel FSM states,
// hold/repeat timer sizing and the saturate/wrap step arithmetic.
package operand_bank_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEAT    = 2'd2
  } chan_state_e;

  // Timer must hold the larger of the two intervals without overflowing.
  function automatic int timerWidth(input int holdDelay, input int repeatPeriod);
    int maxInterval;
    maxInterval = (holdDelay > repeatPeriod) ? holdDelay : repeatPeriod;
    return $clog2(maxInterval + 1);
  endfunction

  // One up/down step on a width-bit value, carried out one bit wider than the
  // operand so the overflow/underflow is visible before clamping or masking.
  function automatic logic [31:0] stepValue(input logic [31:0] cur,
                                            input logic        goUp,
                                            input int          step,
                                            input int          width,
                                            input logic        wrap);
    logic [32:0] maxVal;
    logic [32:0] stepExt;
    logic [32:0] curExt;
    logic [32:0] result;
    maxVal  = (33'd1 << width) - 33'd1;
    stepExt = 33'(step);
    curExt  = {1'b0, cur};
    if (goUp) begin
      result = curExt + stepExt;
      if (wrap) begin
        result = result & maxVal;
      end else if (result > maxVal) begin
        result = maxVal;
      end
    end else begin
      if (curExt >= stepExt) begin
        result = curExt - stepExt;
      end else if (wrap) begin
        result = (curExt - stepExt) & maxVal;
      end else begin
        result = '0;
      end
    end
    return result[31:0];
  endfunction

endpackage

// File: rtl/operand_counter_channel.sv
// One operand channel: press-and-hold FSM with auto-repeat timer and the
// count register. Clear and load override a step but leave the FSM running.
module operand_counter_channel
  import operand_bank_pkg::*;
#(
  parameter int WIDTH_COUNTER = 8,
  parameter int STEP_COUNTER  = 1,
  parameter int WRAP_MODE     = 0,
  parameter int HOLD_DELAY    = 5_000_000,
  parameter int REPEAT_PERIOD = 1_000_000
) (
  input  logic                     clk_100,
  input  logic                     reset_sw_n,
  input  logic                     i_up,
  input  logic                     i_down,
  input  logic                     i_clear,
  input  logic                     i_load,
  input  logic [WIDTH_COUNTER-1:0] i_loadValue,
  output logic [WIDTH_COUNTER-1:0] o_count,
  output logic                     o_stepPulse
);

  localparam int TW = timerWidth(HOLD_DELAY, REPEAT_PERIOD);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_DELAY - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_PERIOD - 1);

  chan_state_e              r_state;
  chan_state_e              w_stateNext;
  logic [TW-1:0]            r_timer;
  logic [TW-1:0]            w_timerNext;
  logic                     r_upLevel;
  logic                     r_downLevel;
  logic                     r_dirUp;
  logic                     w_dirUpNext;
  logic                     w_stepEn;
  logic                     w_held;
  logic [WIDTH_COUNTER-1:0] r_count;
  logic [WIDTH_COUNTER-1:0] w_countNext;
  logic [WIDTH_COUNTER-1:0] w_stepResult;
  logic                     r_stepPulse;

  // Only the remembered button, alone, counts as still being held.
  assign w_held = r_dirUp ? (i_up & ~i_down) : (i_down & ~i_up);

  assign w_stepResult = WIDTH_COUNTER'(stepValue(32'(r_count), w_dirUpNext,
                                                 STEP_COUNTER, WIDTH_COUNTER,
                                                 WRAP_MODE != 0));

  // Next-state logic: first step on the press edge, then hold delay, then repeat.
  always_comb begin
    w_stateNext = r_state;
    w_timerNext = r_timer;
    w_dirUpNext = r_dirUp;
    w_stepEn    = 1'b0;
    case (r_state)
      IDLE: begin
        w_timerNext = '0;
        if (i_up && !i_down && !r_upLevel) begin
          w_stepEn    = 1'b1;
          w_dirUpNext = 1'b1;
          w_stateNext = HOLD_WAIT;
        end else if (i_down && !i_up && !r_downLevel) begin
          w_stepEn    = 1'b1;
          w_dirUpNext = 1'b0;
          w_stateNext = HOLD_WAIT;
        end
      end
      HOLD_WAIT: begin
        if (!w_held) begin
          w_stateNext = IDLE;
          w_timerNext = '0;
        end else if (r_timer == HOLD_LAST) begin
          w_stepEn    = 1'b1;
          w_stateNext = REPEAT;
          w_timerNext = '0;
        end else begin
          w_timerNext = r_timer + TW'(1);
        end
      end
      REPEAT: begin
        if (!w_held) begin
          w_stateNext = IDLE;
          w_timerNext = '0;
        end else if (r_timer == REPEAT_LAST) begin
          w_stepEn    = 1'b1;
          w_timerNext = '0;
        end else begin
          w_timerNext = r_timer + TW'(1);
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_timerNext = '0;
      end
    endcase
  end

  // Count update with clear over load over step.
  always_comb begin
    w_countNext = r_count;
    if (i_clear) begin
      w_countNext = '0;
    end else if (i_load) begin
      w_countNext = i_loadValue;
    end else if (w_stepEn) begin
      w_countNext = w_stepResult;
    end
  end

  // FSM, timer and button history registers.
  always_ff @(posedge clk_100 or negedge reset_sw_n) begin
    if (!reset_sw_n) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_dirUp     <= 1'b0;
      r_upLevel   <= 1'b0;
      r_downLevel <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_timer     <= w_timerNext;
      r_dirUp     <= w_dirUpNext;
      r_upLevel   <= i_up;
      r_downLevel <= i_down;
    end
  end

  // Count register; the pulse marks the cycle in which a new value appears.
  always_ff @(posedge clk_100 or negedge reset_sw_n) begin
    if (!reset_sw_n) begin
      r_count     <= '0;
      r_stepPulse <= 1'b0;
    end else begin
      r_count     <= w_countNext;
      r_stepPulse <= (w_countNext != r_count);
    end
  end

  assign o_count     = r_count;
  assign o_stepPulse = r_stepPulse;

endmodule

// File: rtl/operand_counter_bank.sv
// N-channel operand generator: per-channel counters, load/clear decode,
// flattened count bus and bound flags for the operand mux and display path.
module operand_counter_bank
  import operand_bank_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int WIDTH_COUNTER = 8,
  parameter int STEP_COUNTER  = 1,
  parameter int WRAP_MODE     = 0,
  parameter int HOLD_DELAY    = 5_000_000,
  parameter int REPEAT_PERIOD = 1_000_000,
  localparam int LOAD_CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                              clk_100,
  input  logic                              reset_sw_n,
  input  logic [NUM_CH-1:0]                 up,
  input  logic [NUM_CH-1:0]                 down,
  input  logic                              clear,
  input  logic                              load_en,
  input  logic [LOAD_CH_W-1:0]              load_ch,
  input  logic [WIDTH_COUNTER-1:0]          load_value,
  output logic [NUM_CH*WIDTH_COUNTER-1:0]   count_flat,
  output logic [NUM_CH-1:0]                 step_pulse,
  output logic [NUM_CH-1:0]                 at_max,
  output logic [NUM_CH-1:0]                 at_min
);

  logic [NUM_CH-1:0]        w_loadSel;
  logic [WIDTH_COUNTER-1:0] w_count [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // An out-of-range load_ch matches no channel, so the load is dropped.
    assign w_loadSel[g] = load_en && (load_ch == LOAD_CH_W'(g));

    operand_counter_channel #(
      .WIDTH_COUNTER (WIDTH_COUNTER),
      .STEP_COUNTER  (STEP_COUNTER),
      .WRAP_MODE     (WRAP_MODE),
      .HOLD_DELAY    (HOLD_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_channel (
      .clk_100     (clk_100),
      .reset_sw_n  (reset_sw_n),
      .i_up        (up[g]),
      .i_down      (down[g]),
      .i_clear     (clear),
      .i_load      (w_loadSel[g]),
      .i_loadValue (load_value),
      .o_count     (w_count[g]),
      .o_stepPulse (step_pulse[g])
    );

    assign count_flat[g*WIDTH_COUNTER +: WIDTH_COUNTER] = w_count[g];
  end

  // Bound flags straight from the count registers.
  always_comb begin
    at_max = '0;
    at_min = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      at_max[i] = &w_count[i];
      at_min[i] = ~|w_count[i];
    end
  end

endmodule

// File: tb/tb_operand_counter_bank.sv
// Bench for operand_counter_bank: a saturating 2-channel bank (A) and a
// wrapping 3-channel bank (B) share clock and reset; per-edge expectations
// go into a scoreboard queue and are compared just after each rising edge.
`timescale 1ns/1ps
module tb_operand_counter_bank;

  localparam int HOLD = 10;
  localparam int REP  = 4;

  logic clock = 1'b0;
  logic resetN;

  logic [1:0]  upA, downA;
  logic        clearA, loadEnA;
  logic [0:0]  loadChA;
  logic [7:0]  loadValA;
  logic [15:0] countA;
  logic [1:0]  pulseA, maxA, minA;

  logic [2:0]  upB, downB;
  logic        clearB, loadEnB;
  logic [1:0]  loadChB;
  logic [7:0]  loadValB;
  logic [23:0] countB;
  logic [2:0]  pulseB, maxB, minB;

  typedef struct {
    string tag;
    int    dut;
    int    ch;
    int    cnt;
    int    pulse;
  } exp_t;

  exp_t sbQ[$];
  int   vectorCount = 0;
  int   missCount   = 0;
  int   endVal;

  always #5 clock = ~clock;

  operand_counter_bank #(
    .NUM_CH(2), .WIDTH_COUNTER(8), .STEP_COUNTER(1), .WRAP_MODE(0),
    .HOLD_DELAY(HOLD), .REPEAT_PERIOD(REP)
  ) dutA (
    .clk_100(clock), .reset_sw_n(resetN), .up(upA), .down(downA),
    .clear(clearA), .load_en(loadEnA), .load_ch(loadChA), .load_value(loadValA),
    .count_flat(countA), .step_pulse(pulseA), .at_max(maxA), .at_min(minA)
  );

  operand_counter_bank #(
    .NUM_CH(3), .WIDTH_COUNTER(8), .STEP_COUNTER(1), .WRAP_MODE(1),
    .HOLD_DELAY(HOLD), .REPEAT_PERIOD(REP)
  ) dutB (
    .clk_100(clock), .reset_sw_n(resetN), .up(upB), .down(downB),
    .clear(clearB), .load_en(loadEnB), .load_ch(loadChB), .load_value(loadValB),
    .count_flat(countB), .step_pulse(pulseB), .at_max(maxB), .at_min(minB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] readCount(input int dut, input int ch);
    return (dut == 0) ? countA[ch*8 +: 8] : countB[ch*8 +: 8];
  endfunction

  function automatic logic readPulse(input int dut, input int ch);
    return (dut == 0) ? pulseA[ch] : pulseB[ch];
  endfunction

  // Saturate/wrap arithmetic for an 8-bit operand with a step of 1.
  function automatic int modelStep(input int cur, input bit isUp, input bit wrap);
    int n;
    n = isUp ? cur + 1 : cur - 1;
    if (n > 255) n = wrap ? n - 256 : 255;
    if (n < 0)   n = wrap ? n + 256 : 0;
    return n;
  endfunction

  task automatic expectCount(input string tag, input int dut, input int ch,
                             input int cnt, input int pulse);
    exp_t e;
    e.tag = tag; e.dut = dut; e.ch = ch; e.cnt = cnt; e.pulse = pulse;
    sbQ.push_back(e);
  endtask

  task automatic drainScoreboard();
    exp_t e;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput({e.tag, ".cnt"}, 32'(readCount(e.dut, e.ch)), e.cnt);
      checkOutput({e.tag, ".pulse"}, 32'(readPulse(e.dut, e.ch)), e.pulse);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clock);
      #1;
      drainScoreboard();
    end
  endtask

  task automatic setButton(input int dut, input int ch, input bit isUp, input logic lvl);
    if (dut == 0) begin
      if (isUp) upA[ch] = lvl; else downA[ch] = lvl;
    end else begin
      if (isUp) upB[ch] = lvl; else downB[ch] = lvl;
    end
  endtask

  // Press and hold one button: steps on the press edge, after HOLD more
  // edges, then every REP edges; optional release followed by idle edges.
  task automatic holdTest(input string tag, input int dut, input int ch, input bit isUp,
                          input int startVal, input int cycles, input bit wrap,
                          input bit doRelease, input int idleAfter, output int finalVal);
    int cur;
    int nxt;
    bit stepNow;
    cur = startVal;
    setButton(dut, ch, isUp, 1'b1);
    for (int k = 0; k < cycles; k++) begin
      stepNow = (k == 0) || (k >= HOLD && ((k - HOLD) % REP) == 0);
      nxt = stepNow ? modelStep(cur, isUp, wrap) : cur;
      expectCount($sformatf("%s.k%0d", tag, k), dut, ch, nxt, (nxt != cur) ? 1 : 0);
      applyStimulus(1);
      cur = nxt;
    end
    if (doRelease) begin
      setButton(dut, ch, isUp, 1'b0);
      for (int k = 0; k <= idleAfter; k++) begin
        expectCount($sformatf("%s.rel%0d", tag, k), dut, ch, cur, 0);
        applyStimulus(1);
      end
    end
    finalVal = cur;
  endtask

  // Watchdog so the run always ends even if the clock process stalls.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN = 1'b0;
    upA = '0; downA = '0; clearA = 1'b0; loadEnA = 1'b0; loadChA = '0; loadValA = '0;
    upB = '0; downB = '0; clearB = 1'b0; loadEnB = 1'b0; loadChB = '0; loadValB = '0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst.countA", 32'(countA), 0);
    checkOutput("rst.pulseA", 32'(pulseA), 0);
    checkOutput("rst.minA", 32'(minA), 3);
    checkOutput("rst.maxA", 32'(maxA), 0);
    checkOutput("rst.countB", 32'(countB), 0);
    checkOutput("rst.minB", 32'(minB), 7);
    checkOutput("rst.maxB", 32'(maxB), 0);
    resetN = 1'b1;
    expectCount("idle.a0", 0, 0, 0, 0);
    applyStimulus(2);

    $display("[TB] single tap");
    holdTest("t1", 0, 0, 1'b1, 0, 3, 1'b0, 1'b1, 2, endVal);
    expectCount("t1.ch1", 0, 1, 0, 0);
    applyStimulus(1);

    $display("[TB] hold with auto-repeat");
    holdTest("t2", 0, 1, 1'b1, 0, 30, 1'b0, 1'b1, 8, endVal);
    checkOutput("t2.ch1final", 32'(countA[15:8]), 6);

    $display("[TB] saturate and wrap at the top");
    loadEnA = 1'b1; loadChA = 1'b0; loadValA = 8'd254;
    expectCount("t3.loadA", 0, 0, 254, 1);
    applyStimulus(1);
    loadEnA = 1'b0;
    holdTest("t3.sat", 0, 0, 1'b1, 254, 20, 1'b0, 1'b1, 2, endVal);
    checkOutput("t3.atMax0", 32'(maxA[0]), 1);
    checkOutput("t3.atMin0", 32'(minA[0]), 0);
    loadEnB = 1'b1; loadChB = 2'd0; loadValB = 8'd254;
    expectCount("t3.loadB", 1, 0, 254, 1);
    applyStimulus(1);
    loadEnB = 1'b0;
    holdTest("t3.wrap", 1, 0, 1'b1, 254, 15, 1'b1, 1'b1, 2, endVal);
    checkOutput("t3.wrapVal", 32'(countB[7:0]), 1);

    $display("[TB] down at zero");
    clearA = 1'b1;
    expectCount("t4.clr0", 0, 0, 0, 1);
    expectCount("t4.clr1", 0, 1, 0, 1);
    applyStimulus(1);
    clearA = 1'b0;
    holdTest("t4.sat", 0, 1, 1'b0, 0, 12, 1'b0, 1'b1, 2, endVal);
    checkOutput("t4.atMin1", 32'(minA[1]), 1);
    holdTest("t4.wrap", 1, 1, 1'b0, 0, 3, 1'b1, 1'b1, 2, endVal);
    checkOutput("t4.wrapMax1", 32'(maxB[1]), 1);

    $display("[TB] clear/load/step priority");
    loadEnA = 1'b1; loadChA = 1'b0; loadValA = 8'h10;
    expectCount("t5.pre", 0, 0, 16, 1);
    applyStimulus(1);
    clearA = 1'b1; loadValA = 8'h55; upA[0] = 1'b1;
    expectCount("t5.clrWins", 0, 0, 0, 1);
    applyStimulus(1);
    clearA = 1'b0; loadEnA = 1'b0;
    expectCount("t5.hold0", 0, 0, 0, 0);
    applyStimulus(1);
    expectCount("t5.hold1", 0, 0, 0, 0);
    applyStimulus(1);
    upA[0] = 1'b0;
    expectCount("t5.rel", 0, 0, 0, 0);
    applyStimulus(1);
    loadEnA = 1'b1; upA[0] = 1'b1;
    expectCount("t5.loadWins", 0, 0, 85, 1);
    applyStimulus(1);
    loadEnA = 1'b0; upA[0] = 1'b0;
    expectCount("t5.after", 0, 0, 85, 0);
    applyStimulus(2);
    loadEnB = 1'b1; loadChB = 2'd3; loadValB = 8'h77;
    expectCount("t5.bad0", 1, 0, 1, 0);
    expectCount("t5.bad1", 1, 1, 255, 0);
    expectCount("t5.bad2", 1, 2, 0, 0);
    applyStimulus(1);
    loadChB = 2'd2;
    expectCount("t5.ch2", 1, 2, 119, 1);
    expectCount("t5.ch0", 1, 0, 1, 0);
    applyStimulus(1);
    loadEnB = 1'b0;

    $display("[TB] both buttons and reset during repeat");
    upA[0] = 1'b1; downA[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expectCount($sformatf("t6.both%0d", k), 0, 0, 85, 0);
      applyStimulus(1);
    end
    upA[0] = 1'b0; downA[0] = 1'b0;
    expectCount("t6.bothRel", 0, 0, 85, 0);
    applyStimulus(1);
    holdTest("t6.rep", 0, 1, 1'b1, 0, 16, 1'b0, 1'b0, 0, endVal);
    resetN = 1'b0;
    #2;
    checkOutput("t6.rstCh1", 32'(countA[15:8]), 0);
    checkOutput("t6.rstCh0", 32'(countA[7:0]), 0);
    checkOutput("t6.rstPulse", 32'(pulseA), 0);
    upA[1] = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expectCount($sformatf("t6.quiet%0d", k), 0, 1, 0, 0);
      applyStimulus(1);
    end
    holdTest("t6.fresh", 0, 1, 1'b1, 0, 12, 1'b0, 1'b1, 2, endVal);
    checkOutput("t6.freshVal", 32'(countA[15:8]), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/operand_counter_bank.md
Name: operand_counter_bank

Overview:
Parametrised N-channel operand generator for the ALU/DSP datapath. It replaces the fixed two-channel up/down operand counters with a channel-generic bank. Each channel is driven by debounced up/down switch levels and has press-and-hold auto-repeat, a selectable saturate or wrap mode, a synchronous per-channel load, and a global clear. Outputs feed the operand mux, which produces num_1/num_2 toward the DSP, and the display path.

Parameters:
NUM_CH, 2, number of operand channels (1..8)
WIDTH_COUNTER, 8, operand width in bits
STEP_COUNTER, 1, increment/decrement magnitude per step (1..2^WIDTH_COUNTER-1)
WRAP_MODE, 0, 0 = saturate at 0 / max; 1 = wrap modulo 2^WIDTH_COUNTER
HOLD_DELAY, 5_000_000, cycles a button must be held after the first step before auto-repeat starts (>=1)
REPEAT_PERIOD, 1_000_000, cycles between auto-repeat steps (>=1)

Ports:
clk_100  input  1  system clock, all logic on rising edge
reset_sw_n  input  1  asynchronous active-low reset
up  input  NUM_CH  debounced up-button level per channel, synchronous to clk_100
down  input  NUM_CH  debounced down-button level per channel, synchronous to clk_100
clear  input  1  synchronous clear of all channels to 0
load_en  input  1  synchronous load strobe
load_ch  input  $clog2(NUM_CH) (min 1)  channel index for load
load_value  input  WIDTH_COUNTER  value to load
count_flat  output  NUM_CH*WIDTH_COUNTER  channel i value at bits [i*W +: W]
step_pulse  output  NUM_CH  1-cycle pulse in the cycle after a channel's count changed
at_max  output  NUM_CH  channel count == 2^W-1
at_min  output  NUM_CH  channel count == 0

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - all counts = 0, step_pulse = 0, at_min = all 1, at_max = all 0
  - all FSMs in IDLE, hold timers = 0, registered button levels = 0
- Per-channel FSM states: IDLE, HOLD_WAIT, REPEAT.
  - IDLE: a rising edge on exactly one of up/down (current level 1, registered level 0) produces one step on that clock edge, clears the timer, and moves to HOLD_WAIT.
  - HOLD_WAIT: the timer counts while the same single button stays held. When the timer reaches HOLD_DELAY-1, the next edge produces a step, clears the timer, and moves to REPEAT.
  - REPEAT: a step occurs every REPEAT_PERIOD cycles while the button is held.
  - Release, the other button asserting, or both asserted: return to IDLE next edge with no step. Both asserted from IDLE also produces no step.
- Latency: count is visible one clock after the rising input level is sampled. step_pulse is registered and aligned with the new count value.
- Arithmetic:
  - Computed in W+1 bits.
  - Saturate mode: up clamps to 2^W-1 and down clamps to 0. A step that would exceed a bound lands exactly on the bound, e.g. 254+STEP 4 = 255.
  - Wrap mode: result is modulo 2^W (255+1 = 0, 0-1 = 255).
  - A saturated step with no value change produces no step_pulse. The FSM still advances.
- Priority per edge: clear > load_en (on channel load_ch) > up/down step.
  - clear and load_en do not reset the FSM state or timer.
  - A step coinciding with load or clear on that channel is discarded.
  - Loading or clearing to a different value pulses step_pulse.
- load_ch >= NUM_CH: load ignored.
- at_max/at_min are derived combinationally from the count registers.
- Timer width: $clog2(max(HOLD_DELAY, REPEAT_PERIOD)+1). The timer never overflows; it is cleared on every state change.

Decomposition:
- Shared package operand_bank_pkg:
  - FSM state enum (IDLE, HOLD_WAIT, REPEAT)
  - function for the timer width
  - saturate/wrap step function
- Sub-module operand_counter_channel: one FSM, timer, and count register, instantiated NUM_CH times by generate.
- The top level handles clear/load decode, flattening, and flags.

Test Plan:
Common bench setup: W=8, STEP=1, HOLD_DELAY=10, REPEAT_PERIOD=4, NUM_CH=2.
1. Reset then single tap: up[0] high 3 cycles → ch0 = 1 one clock after the rise, a single step_pulse[0], ch1 = 0.
2. Hold up[1] for 30 cycles from 0 → steps at cycles 1, 11, 15, 19, 23, 27 giving ch1 = 6; release → IDLE, no further steps.
3. Saturate: load ch0 = 254, hold up[0] into REPEAT → 255 then stays 255, at_max[0] = 1, no step_pulse after reaching 255. Repeat with WRAP_MODE = 1 → 255→0→1.
4. Down at 0 in saturate mode → stays 0, no step_pulse, at_min = 1. In wrap mode → 255.
5. Priority: clear, load_en (ch0 = 0x55) and an up[0] edge in the same cycle → ch0 = 0. Then load_en + up[0] edge → ch0 = 0x55, step discarded. load_ch = 3 → no effect.
6. up[0] and down[0] asserted together from IDLE → no change. Assert reset_sw_n = 0 mid-REPEAT → counts 0 immediately, FSM IDLE; held button after release needs a new edge to step.
